// File: rtl/dcache_victim_buffer_pkg.sv
// Shared types and default sizes for the data-cache victim buffer.
// Build option DCACHE_VB_LRU_EN selects LRU replacement in dcache_vb_repl.
package dcache_victim_buffer_pkg;

  localparam int VB_ENTRIES     = 4;
  localparam int VB_LINE_WIDTH  = 128;
  localparam int VB_LADDR_WIDTH = 28;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FLUSH_SCAN,
    FLUSH_WB,
    FLUSH_DONE
  } type_vb_state_e;

  typedef struct packed {
    logic                      valid;
    logic                      dirty;
    logic [VB_LADDR_WIDTH-1:0] laddr;
    logic [VB_LINE_WIDTH-1:0]  data;
  } type_vb_entry_s;

endpackage

// File: rtl/dcache_victim_buffer_if.sv
// Cache-side and memory-side signal bundle of the victim buffer.
// master = cache/memory driver, slave = victim buffer.
interface dcache_vb_if
  import dcache_victim_buffer_pkg::*;
#(
  parameter int LINE_WIDTH  = VB_LINE_WIDTH,
  parameter int LADDR_WIDTH = VB_LADDR_WIDTH
);
  logic                   lookup_req_i;
  logic [LADDR_WIDTH-1:0] lookup_laddr_i;
  logic                   lookup_take_i;
  logic                   lookup_valid_o;
  logic                   lookup_hit_o;
  logic [LINE_WIDTH-1:0]  lookup_data_o;
  logic                   lookup_dirty_o;
  logic                   insert_req_i;
  logic [LADDR_WIDTH-1:0] insert_laddr_i;
  logic [LINE_WIDTH-1:0]  insert_data_i;
  logic                   insert_dirty_i;
  logic                   insert_ready_o;
  logic                   flush_i;
  logic                   flush_done_o;
  logic                   wb_req_o;
  logic [LADDR_WIDTH-1:0] wb_laddr_o;
  logic [LINE_WIDTH-1:0]  wb_data_o;
  logic                   wb_ack_i;

  modport master (
    output lookup_req_i, lookup_laddr_i,
    output lookup_take_i,
    input  lookup_valid_o, lookup_hit_o,
    input  lookup_data_o, lookup_dirty_o,
    output insert_req_i, insert_laddr_i,
    output insert_data_i, insert_dirty_i,
    input  insert_ready_o,
    output flush_i,
    input  flush_done_o,
    input  wb_req_o, wb_laddr_o, wb_data_o,
    output wb_ack_i
  );

  modport slave (
    input  lookup_req_i, lookup_laddr_i,
    input  lookup_take_i,
    output lookup_valid_o, lookup_hit_o,
    output lookup_data_o, lookup_dirty_o,
    input  insert_req_i, insert_laddr_i,
    input  insert_data_i, insert_dirty_i,
    output insert_ready_o,
    input  flush_i,
    output flush_done_o,
    output wb_req_o, wb_laddr_o, wb_data_o,
    input  wb_ack_i
  );
endinterface

// File: rtl/dcache_victim_buffer_repl.sv
// Victim-buffer replacement: round-robin pointer, or per-entry
// age counters when DCACHE_VB_LRU_EN is defined.
module dcache_vb_repl
  import dcache_victim_buffer_pkg::*;
#(
  parameter int N  = VB_ENTRIES,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          touch_i,
  input  logic [IW-1:0] touch_idx_i,
  input  logic          full_i,
  output logic [IW-1:0] victim_o
);

`ifdef DCACHE_VB_LRU_EN
  logic [IW-1:0] age_q [N];
  logic [IW-1:0] age_d [N];
  logic          unused_full;

  assign unused_full = full_i;

  // Ages stay a permutation, so the oldest is always N-1
  always_comb begin
    age_d    = age_q;
    victim_o = '0;
    if (touch_i) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == touch_idx_i)
          age_d[i] = '0;
        else if (age_q[i] < age_q[touch_idx_i])
          age_d[i] = age_q[i] + 1'b1;
      end
    end
    for (int i = 0; i < N; i++)
      if (age_q[i] == IW'(N - 1))
        victim_o = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        age_q[i] <= IW'(i);
    end else begin
      age_q <= age_d;
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] unused_idx;

  assign unused_idx = touch_idx_i;
  assign victim_o   = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (touch_i && full_i)
      ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/dcache_victim_buffer.sv
// Fully associative victim buffer between D-cache and memory port.
// Define DCACHE_VB_LRU_EN for LRU instead of round-robin victims.
module dcache_victim_buffer
  import dcache_victim_buffer_pkg::*;
#(
  parameter int VC_ENTRIES  = VB_ENTRIES,
  parameter int LINE_WIDTH  = VB_LINE_WIDTH,
  parameter int LADDR_WIDTH = VB_LADDR_WIDTH
) (
  input logic        clk,
  input logic        rst,
  dcache_vb_if.slave vb
);
  localparam int IW = $clog2(VC_ENTRIES);

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [LADDR_WIDTH-1:0] laddr;
    logic [LINE_WIDTH-1:0]  data;
  } ent_t;

  ent_t                   ent_q [VC_ENTRIES];
  ent_t                   ent_d [VC_ENTRIES];
  type_vb_state_e         state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [LADDR_WIDTH-1:0] wb_laddr_q, wb_laddr_d;
  logic [LINE_WIDTH-1:0]  wb_data_q, wb_data_d;
  logic                   pend_q, pend_d;
  logic                   lk_valid_q, lk_valid_d;
  logic                   lk_hit_q, lk_hit_d;
  logic                   lk_dirty_q, lk_dirty_d;
  logic [LINE_WIDTH-1:0]  lk_data_q, lk_data_d;

  logic [VC_ENTRIES-1:0] lk_match, ins_match;
  logic [IW-1:0]         lk_idx, ins_idx, free_idx;
  logic [IW-1:0]         victim, touch_idx;
  logic                  have_free, lk_hit, ins_fire;
  logic                  touch, repl_full;

  dcache_vb_repl #(.N(VC_ENTRIES)) u_repl (
    .clk        (clk),
    .rst        (rst),
    .touch_i    (touch),
    .touch_idx_i(touch_idx),
    .full_i     (repl_full),
    .victim_o   (victim)
  );

  always_comb begin
    lk_idx    = '0;
    ins_idx   = '0;
    free_idx  = '0;
    have_free = 1'b0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      lk_match[i]  = ent_q[i].valid &&
                     ent_q[i].laddr == vb.lookup_laddr_i;
      ins_match[i] = ent_q[i].valid &&
                     ent_q[i].laddr == vb.insert_laddr_i;
      if (lk_match[i])  lk_idx  = IW'(i);
      if (ins_match[i]) ins_idx = IW'(i);
      if (!ent_q[i].valid) begin
        free_idx  = IW'(i);
        have_free = 1'b1;
      end
    end
    lk_hit   = vb.lookup_req_i && |lk_match;
    ins_fire = vb.insert_req_i && state_q == IDLE;
  end

  always_comb begin
    ent_d      = ent_q;
    state_d    = state_q;
    idx_d      = idx_q;
    wb_laddr_d = wb_laddr_q;
    wb_data_d  = wb_data_q;
    pend_d     = pend_q;
    touch      = 1'b0;
    touch_idx  = lk_idx;
    repl_full  = 1'b0;
    lk_valid_d = vb.lookup_req_i;
    lk_hit_d   = lk_hit;
    lk_data_d  = lk_hit ? ent_q[lk_idx].data : '0;
    lk_dirty_d = lk_hit && ent_q[lk_idx].dirty;

    if (lk_hit) begin
      touch = 1'b1;
      if (vb.lookup_take_i) begin
        ent_d[lk_idx].valid = 1'b0;
        ent_d[lk_idx].dirty = 1'b0;
      end
    end

    // Slot choice uses pre-edge state; a same-cycle take stays hidden
    if (ins_fire) begin
      touch = 1'b1;
      if (|ins_match) begin
        touch_idx = ins_idx;
        ent_d[ins_idx].valid = 1'b1;
        ent_d[ins_idx].data  = vb.insert_data_i;
        ent_d[ins_idx].dirty = ent_q[ins_idx].dirty |
                               vb.insert_dirty_i;
      end else begin
        touch_idx = have_free ? free_idx : victim;
        repl_full = !have_free;
        if (!have_free && ent_q[victim].dirty) begin
          wb_laddr_d = ent_q[victim].laddr;
          wb_data_d  = ent_q[victim].data;
          state_d    = WB;
        end
        ent_d[touch_idx].valid = 1'b1;
        ent_d[touch_idx].dirty = vb.insert_dirty_i;
        ent_d[touch_idx].laddr = vb.insert_laddr_i;
        ent_d[touch_idx].data  = vb.insert_data_i;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (vb.flush_i) begin
          idx_d = '0;
          if (state_d == WB) pend_d  = 1'b1;
          else               state_d = FLUSH_SCAN;
        end
      end
      WB: begin
        if (vb.wb_ack_i) begin
          state_d = (vb.flush_i || pend_q) ? FLUSH_SCAN : IDLE;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      FLUSH_SCAN, FLUSH_WB: begin
        if (state_q == FLUSH_SCAN &&
            ent_q[idx_q].valid && ent_q[idx_q].dirty) begin
          wb_laddr_d = ent_q[idx_q].laddr;
          wb_data_d  = ent_q[idx_q].data;
          state_d    = FLUSH_WB;
        end else if (state_q == FLUSH_SCAN || vb.wb_ack_i) begin
          ent_d[idx_q].valid = 1'b0;
          ent_d[idx_q].dirty = 1'b0;
          if (idx_q == IW'(VC_ENTRIES - 1)) begin
            state_d = FLUSH_DONE;
          end else begin
            state_d = FLUSH_SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      FLUSH_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC_ENTRIES; i++)
        ent_q[i] <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      wb_laddr_q <= '0;
      wb_data_q  <= '0;
      pend_q     <= 1'b0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_dirty_q <= 1'b0;
      lk_data_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      wb_laddr_q <= wb_laddr_d;
      wb_data_q  <= wb_data_d;
      pend_q     <= pend_d;
      lk_valid_q <= lk_valid_d;
      lk_hit_q   <= lk_hit_d;
      lk_dirty_q <= lk_dirty_d;
      lk_data_q  <= lk_data_d;
    end
  end

  assign vb.lookup_valid_o = lk_valid_q;
  assign vb.lookup_hit_o   = lk_hit_q;
  assign vb.lookup_data_o  = lk_data_q;
  assign vb.lookup_dirty_o = lk_dirty_q;
  assign vb.insert_ready_o = state_q == IDLE;
  assign vb.flush_done_o   = state_q == FLUSH_DONE;
  assign vb.wb_req_o       = state_q == WB ||
                             state_q == FLUSH_WB;
  assign vb.wb_laddr_o     = wb_laddr_q;
  assign vb.wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// Directed self-checking bench for dcache_victim_buffer.
module tb_dcache_victim_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dcache_vb_if #(.LINE_WIDTH(128), .LADDR_WIDTH(28)) vb ();

  dcache_victim_buffer #(
    .VC_ENTRIES(4), .LINE_WIDTH(128), .LADDR_WIDTH(28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vb (vb)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkdata(input logic [27:0] l);
    return {4{4'hD, l}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vb.lookup_req_i   = 1'b0;
    vb.lookup_laddr_i = '0;
    vb.lookup_take_i  = 1'b0;
    vb.insert_req_i   = 1'b0;
    vb.insert_laddr_i = '0;
    vb.insert_data_i  = '0;
    vb.insert_dirty_i = 1'b0;
    vb.flush_i        = 1'b0;
    vb.wb_ack_i       = 1'b0;
  endtask

  task automatic ins(input logic [27:0] l, input logic [127:0] d,
                     input logic dirty);
    vb.insert_req_i   = 1'b1;
    vb.insert_laddr_i = l;
    vb.insert_data_i  = d;
    vb.insert_dirty_i = dirty;
    tick();
    vb.insert_req_i   = 1'b0;
    vb.insert_dirty_i = 1'b0;
  endtask

  task automatic look(input logic [27:0] l, input logic take);
    vb.lookup_req_i   = 1'b1;
    vb.lookup_laddr_i = l;
    vb.lookup_take_i  = take;
    tick();
    vb.lookup_req_i   = 1'b0;
    vb.lookup_take_i  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (vb.insert_ready_o !== 1'b1) begin errors++;
      $display("FAIL rst_ready got %b exp 1", vb.insert_ready_o); end
    checks++; if (vb.wb_req_o !== 1'b0) begin errors++;
      $display("FAIL rst_wb_req got %b exp 0", vb.wb_req_o); end
    checks++; if (vb.flush_done_o !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b exp 0", vb.flush_done_o); end
    checks++; if (vb.lookup_valid_o !== 1'b0) begin errors++;
      $display("FAIL rst_lk_valid got %b exp 0", vb.lookup_valid_o); end
    look(28'h100, 1'b0);
    checks++; if (vb.lookup_valid_o !== 1'b1) begin errors++;
      $display("FAIL empty_lk_valid got %b exp 1", vb.lookup_valid_o); end
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL empty_lk_hit got %b exp 0", vb.lookup_hit_o); end
  endtask

  task automatic test_lookup_take();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    ins(28'h100, a5, 1'b0);
    look(28'h100, 1'b1);
    checks++; if (vb.lookup_hit_o !== 1'b1) begin errors++;
      $display("FAIL take_hit got %b exp 1", vb.lookup_hit_o); end
    checks++; if (vb.lookup_data_o !== a5) begin errors++;
      $display("FAIL take_data got %h exp %h", vb.lookup_data_o, a5); end
    checks++; if (vb.lookup_dirty_o !== 1'b0) begin errors++;
      $display("FAIL take_dirty got %b exp 0", vb.lookup_dirty_o); end
    look(28'h100, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL retake_hit got %b exp 0", vb.lookup_hit_o); end
    tick();
    checks++; if (vb.lookup_valid_o !== 1'b0) begin errors++;
      $display("FAIL idle_lk_valid got %b exp 0", vb.lookup_valid_o); end
  endtask

  task automatic test_evict_wb();
    ins(28'h10, mkdata(28'h10), 1'b1);
    for (int i = 1; i < 4; i++)
      ins(28'h10 + 28'(i), mkdata(28'h10 + 28'(i)), 1'b0);
    ins(28'h14, mkdata(28'h14), 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (vb.wb_req_o !== 1'b1) begin errors++;
        $display("FAIL ev_req c%0d got %b exp 1", c, vb.wb_req_o); end
      checks++; if (vb.wb_laddr_o !== 28'h10) begin errors++;
        $display("FAIL ev_laddr c%0d got %h exp 10", c, vb.wb_laddr_o); end
      checks++; if (vb.wb_data_o !== mkdata(28'h10)) begin errors++;
        $display("FAIL ev_data c%0d got %h", c, vb.wb_data_o); end
      checks++; if (vb.insert_ready_o !== 1'b0) begin errors++;
        $display("FAIL ev_ready c%0d got %b exp 0", c, vb.insert_ready_o); end
      if (c < 3) tick();
    end
    vb.wb_ack_i = 1'b1;
    tick();
    vb.wb_ack_i = 1'b0;
    checks++; if (vb.wb_req_o !== 1'b0) begin errors++;
      $display("FAIL ev_ack_req got %b exp 0", vb.wb_req_o); end
    checks++; if (vb.insert_ready_o !== 1'b1) begin errors++;
      $display("FAIL ev_ack_ready got %b exp 1", vb.insert_ready_o); end
    look(28'h14, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b1) begin errors++;
      $display("FAIL ev_new_hit got %b exp 1", vb.lookup_hit_o); end
    look(28'h10, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL ev_old_hit got %b exp 0", vb.lookup_hit_o); end
  endtask

  task automatic test_flush();
    logic [27:0] wbl [4];
    int nwb;
    int ndone;
    nwb   = 0;
    ndone = 0;
    ins(28'h11, mkdata(28'h11), 1'b1);
    ins(28'h13, mkdata(28'h13), 1'b1);
    look(28'h11, 1'b0);
    checks++; if (vb.lookup_dirty_o !== 1'b1) begin errors++;
      $display("FAIL fl_dirty_merge got %b exp 1", vb.lookup_dirty_o); end
    vb.flush_i  = 1'b1;
    vb.wb_ack_i = 1'b1;
    tick();
    vb.flush_i  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (vb.wb_req_o === 1'b1) begin
        if (nwb < 4) wbl[nwb] = vb.wb_laddr_o;
        nwb++;
      end
      if (vb.flush_done_o === 1'b1) ndone++;
    end
    vb.wb_ack_i = 1'b0;
    checks++; if (nwb !== 2) begin errors++;
      $display("FAIL fl_wb_count got %0d exp 2", nwb); end
    if (nwb >= 2) begin
      checks++; if (wbl[0] !== 28'h11) begin errors++;
        $display("FAIL fl_wb0 got %h exp 11", wbl[0]); end
      checks++; if (wbl[1] !== 28'h13) begin errors++;
        $display("FAIL fl_wb1 got %h exp 13", wbl[1]); end
    end
    checks++; if (ndone !== 1) begin errors++;
      $display("FAIL fl_done_pulses got %0d exp 1", ndone); end
    for (int i = 1; i < 5; i++) begin
      look(28'h10 + 28'(i), 1'b0);
      checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
        $display("FAIL fl_miss %0d got %b exp 0", i, vb.lookup_hit_o); end
    end
  endtask

  task automatic test_flush_timing();
    int n;
    n = 0;
    vb.flush_i = 1'b1;
    tick();
    vb.flush_i = 1'b0;
    checks++; if (vb.insert_ready_o !== 1'b0) begin errors++;
      $display("FAIL ft_ready got %b exp 0", vb.insert_ready_o); end
    for (int c = 1; c < 20; c++) begin
      if (n == 0 && vb.flush_done_o === 1'b1) n = c;
      if (n == 0) tick();
    end
    checks++; if (n !== 5) begin errors++;
      $display("FAIL ft_cycles got %0d exp 5", n); end
    tick();
    checks++; if (vb.insert_ready_o !== 1'b1) begin errors++;
      $display("FAIL ft_idle got %b exp 1", vb.insert_ready_o); end
  endtask

  task automatic test_take_and_insert();
    for (int i = 0; i < 4; i++)
      ins(28'h20 + 28'(i), mkdata(28'h20 + 28'(i)), 1'b0);
    vb.lookup_req_i   = 1'b1;
    vb.lookup_laddr_i = 28'h20;
    vb.lookup_take_i  = 1'b1;
    ins(28'h30, mkdata(28'h30), 1'b0);
    vb.lookup_req_i   = 1'b0;
    vb.lookup_take_i  = 1'b0;
    checks++; if (vb.lookup_hit_o !== 1'b1) begin errors++;
      $display("FAIL ti_hit got %b exp 1", vb.lookup_hit_o); end
    checks++; if (vb.lookup_data_o !== mkdata(28'h20)) begin errors++;
      $display("FAIL ti_data got %h", vb.lookup_data_o); end
    checks++; if (vb.insert_ready_o !== 1'b1) begin errors++;
      $display("FAIL ti_ready got %b exp 1", vb.insert_ready_o); end
    look(28'h21, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL ti_victim got %b exp 0", vb.lookup_hit_o); end
    look(28'h30, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b1) begin errors++;
      $display("FAIL ti_new got %b exp 1", vb.lookup_hit_o); end
    look(28'h20, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL ti_taken got %b exp 0", vb.lookup_hit_o); end
    look(28'h22, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b1) begin errors++;
      $display("FAIL ti_keep got %b exp 1", vb.lookup_hit_o); end
  endtask

  task automatic test_insert_flush();
    bit seen;
    seen = 1'b0;
    ins(28'h40, mkdata(28'h40), 1'b0);
    ins(28'h22, mkdata(28'h22), 1'b1);
    vb.flush_i = 1'b1;
    ins(28'h41, mkdata(28'h41), 1'b0);
    vb.flush_i = 1'b0;
    checks++; if (vb.wb_req_o !== 1'b1) begin errors++;
      $display("FAIL if_req got %b exp 1", vb.wb_req_o); end
    checks++; if (vb.wb_laddr_o !== 28'h22) begin errors++;
      $display("FAIL if_laddr got %h exp 22", vb.wb_laddr_o); end
    vb.wb_ack_i = 1'b1;
    tick();
    vb.wb_ack_i = 1'b0;
    checks++; if (vb.insert_ready_o !== 1'b0) begin errors++;
      $display("FAIL if_scan got %b exp 0", vb.insert_ready_o); end
    checks++; if (vb.wb_req_o !== 1'b0) begin errors++;
      $display("FAIL if_req_drop got %b exp 0", vb.wb_req_o); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (vb.flush_done_o === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++;
      $display("FAIL if_done got %b exp 1", seen); end
    look(28'h41, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL if_miss got %b exp 0", vb.lookup_hit_o); end
  endtask

  task automatic test_reset_mid();
    ins(28'h50, mkdata(28'h50), 1'b1);
    vb.flush_i = 1'b1;
    tick();
    vb.flush_i = 1'b0;
    tick();
    checks++; if (vb.wb_req_o !== 1'b1) begin errors++;
      $display("FAIL rm_pre_req got %b exp 1", vb.wb_req_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (vb.wb_req_o !== 1'b0) begin errors++;
      $display("FAIL rm_req got %b exp 0", vb.wb_req_o); end
    checks++; if (vb.insert_ready_o !== 1'b1) begin errors++;
      $display("FAIL rm_ready got %b exp 1", vb.insert_ready_o); end
    look(28'h50, 1'b0);
    checks++; if (vb.lookup_hit_o !== 1'b0) begin errors++;
      $display("FAIL rm_miss got %b exp 0", vb.lookup_hit_o); end
  endtask

  initial begin
    test_reset();
    test_lookup_take();
    test_evict_wb();
    test_flush();
    test_flush_timing();
    test_take_and_insert();
    test_insert_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_victim_buffer.md
Name: dcache_victim_buffer

Overview:
- Parametrised, fully associative victim buffer placed between the write-back data-cache datapath and the data-memory port.
- Holds lines evicted from the data cache, tagged by line address with a dirty bit.
- On a cache miss it returns a matching line so the cache can swap it back in, without a memory access.
- Writes dirty lines back to memory when they are displaced, or on flush; generalises the single-entry victim path to N entries with replacement and flush.

Parameters:
- VC_ENTRIES, 4, number of entries; power of two, 2..16.
- LINE_WIDTH, 128, cache line width in bits.
- LADDR_WIDTH, 28, line address width (byte address minus offset bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- lookup_req_i  in  1  lookup strobe
- lookup_laddr_i  in  LADDR_WIDTH  line address to look up
- lookup_take_i  in  1  on hit, invalidate the entry (swap into cache)
- lookup_valid_o  out  1  lookup result valid, one cycle after lookup_req_i
- lookup_hit_o  out  1  result: hit
- lookup_data_o  out  LINE_WIDTH  hit line data
- lookup_dirty_o  out  1  hit line dirty bit
- insert_req_i  in  1  insert evicted line; accepted only when insert_ready_o=1
- insert_laddr_i  in  LADDR_WIDTH  evicted line address
- insert_data_i  in  LINE_WIDTH  evicted line data
- insert_dirty_i  in  1  evicted line dirty
- insert_ready_o  out  1  buffer can accept an insert this cycle
- flush_i  in  1  pulse: write back all dirty entries, invalidate all
- flush_done_o  out  1  one-cycle pulse when flush completes
- wb_req_o  out  1  memory write request, held until ack
- wb_laddr_o  out  LADDR_WIDTH  write-back line address
- wb_data_o  out  LINE_WIDTH  write-back data
- wb_ack_i  in  1  memory acknowledge

Behaviour:
- Reset (synchronous, active-high):
  - All valid and dirty bits cleared; replacement pointer = 0; state IDLE.
  - All outputs 0, except insert_ready_o = 1.
- Lookup:
  - Registered, latency 1; results held stable only in the valid cycle.
  - Hit requires valid && laddr match; one-hot match is guaranteed.
  - Lookup sees state before same-cycle updates.
  - On hit with take=1, the entry is invalidated at the same edge as the output registers.
  - Lookups are accepted in every state. A lookup to an entry currently being written back still hits; data comes from the entry.
- Insert (handshake insert_req_i && insert_ready_o):
  - If the laddr matches a valid entry, overwrite that entry; dirty |= insert_dirty_i.
  - Else use the lowest-index invalid entry. An entry freed by a same-cycle take is not yet visible.
  - Else (full) use the victim at the replacement pointer:
    - Victim clean: overwrite in place.
    - Victim dirty: copy it to the write-back register, overwrite the entry, go to WB.
  - The replacement pointer increments modulo VC_ENTRIES on every full-buffer replacement.
- FSM states: IDLE, WB, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
  - IDLE: insert_ready_o = 1.
  - WB: wb_req_o = 1 with data from the write-back register; insert_ready_o = 0. On wb_ack_i, go to IDLE next cycle.
  - FLUSH_SCAN: index counter steps 0..VC_ENTRIES-1, one entry per cycle.
    - Valid and dirty entry: go to FLUSH_WB.
    - Otherwise: invalidate the entry and advance.
    - After the last index: go to FLUSH_DONE.
  - FLUSH_WB: wb_req_o = 1 for the entry. On ack, invalidate it and return to FLUSH_SCAN at the next index.
  - FLUSH_DONE: flush_done_o = 1 for one cycle, then IDLE.
  - insert_ready_o = 0 in all flush states.
- flush_i:
  - Sampled only in IDLE, or in WB after the ack, which enters FLUSH_SCAN directly.
  - Ignored while already flushing.
  - flush_i and an insert in the same IDLE cycle: the insert is accepted first; any resulting write-back completes before the scan starts.
- wb_req_o: never deasserted before wb_ack_i; address and data stable while requested.
- A zero-dirty flush takes VC_ENTRIES + 1 cycles to reach flush_done_o.
- Reset mid-operation clears everything; any outstanding wb_req_o drops the next cycle.

Optional Feature:
- Macro: DCACHE_VB_LRU_EN.
- Defined: replace the round-robin pointer with per-entry age counters, each clog2(VC_ENTRIES) bits.
  - On insert or hit, the touched entry's age becomes 0; entries younger than it increment.
  - The victim is the oldest valid entry.
  - Invalidated entries keep their age; ages reset to index order.
- Undefined: round-robin pointer as above.

Decomposition:
- Shared cache package holds:
  - type_vb_entry_s (valid, dirty, laddr, data).
  - FSM enum type_vb_state_e.
  - Default constants VB_ENTRIES and VB_LINE_WIDTH.
- One sub-module, dcache_vb_repl: replacement policy.
  - Round-robin or LRU, selected by the macro.
  - Inputs: touch strobe and index, full flag.
  - Output: victim index.

Test Plan:
- Reset, then lookup 0x100 -> lookup_valid_o = 1 next cycle, hit = 0; insert_ready_o = 1.
- Insert 0x100 (data 0xA5..A5, clean), then lookup 0x100 with take = 1 -> hit = 1, data 0xA5..A5; a repeat lookup -> hit = 0.
- Insert 5 lines 0x10..0x14 (entries 4), 0x10 dirty -> 5th insert:
  - wb_req_o = 1, wb_laddr_o = 0x10, insert_ready_o = 0.
  - Hold ack off 3 cycles -> request and data stable; ack -> IDLE.
- Entries 1 and 3 dirty, flush_i pulse with ack returned immediately:
  - Exactly two write-backs, in index order.
  - flush_done_o pulses once; all lookups then miss.
- Same-cycle lookup take on 0x20 and insert 0x30 into a full buffer -> lookup hits 0x20; insert replaces the pointer victim, not 0x20's slot.
- Assert rst while in FLUSH_WB -> next cycle wb_req_o = 0, insert_ready_o = 1, all entries miss.
